vending_ctrl_gen2: RTL and testbench

//  Parametrised second-generation vending controller: accepts one purchase per handshake
//  (4 denominations 50/10/5/1, items A/B/C), makes greedy change from a coin inventory,
//  and reports completion with a one-cycle done pulse plus a built-in change-correctness flag.
//  New vs gen1: req handshake, inventory-overflow reject, insufficient-funds direct refund,

---
 rtl/vending_ctrl_gen2.sv | 224 ++++++++++++++++++++++
 tb/tb_vending_ctrl_gen2.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vending_ctrl_gen2.sv
// Vending controller: one purchase per req handshake, greedy change from a coin inventory,
// rollback when change is impossible. Define VEND_REFILL_EN to add the idle-time refill port.
module vending_ctrl_gen2 #(
  parameter int unsigned CNT_W    = 3,
  parameter int unsigned IN_W     = 2,
  parameter int unsigned VAL_W    = 8,
  parameter int unsigned INIT_CNT = 2,
  parameter int unsigned COST_A   = 8,
  parameter int unsigned COST_B   = 15,
  parameter int unsigned COST_C   = 22
) (
  input  logic             clk_i,
  input  logic             reset_ni,
  input  logic             req_valid_i,
  output logic             req_ready_o,
  input  logic [1:0]       item_in_i,
  input  logic [IN_W-1:0]  coin_in_50_i,
  input  logic [IN_W-1:0]  coin_in_10_i,
  input  logic [IN_W-1:0]  coin_in_5_i,
  input  logic [IN_W-1:0]  coin_in_1_i,
  output logic [CNT_W-1:0] coin_out_50_o,
  output logic [CNT_W-1:0] coin_out_10_o,
  output logic [CNT_W-1:0] coin_out_5_o,
  output logic [CNT_W-1:0] coin_out_1_o,
  output logic [1:0]       item_out_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [VAL_W-1:0] input_value_o,
  output logic             prop_ok_o
`ifdef VEND_REFILL_EN
  ,
  input  logic             refill_valid_i,
  input  logic [1:0]       refill_denom_i,
  input  logic [CNT_W-1:0] refill_num_i,
  output logic             refill_ready_o
`endif
);

  localparam int unsigned MaxCnt = (2 ** CNT_W) - 1;
  localparam int unsigned SumW   = ((CNT_W > IN_W) ? CNT_W : IN_W) + 1;

  typedef enum logic [2:0] {StIdle, StCheck, StChange, StRollback, StDone} state_e;

  // Denomination index: 0 = 50, 1 = 10, 2 = 5, 3 = 1.
  state_e             state_q;
  logic [CNT_W-1:0]   inv_q      [4];
  logic [IN_W-1:0]    coin_in_q  [4];
  logic [CNT_W-1:0]   coin_out_q [4];
  logic [1:0]         item_q;
  logic [1:0]         item_out_q;
  logic [VAL_W-1:0]   value_q;
  logic [VAL_W-1:0]   remain_q;
  logic [1:0]         denom_q;
  logic               done_q;

  logic               accept;
  logic [IN_W-1:0]    coin_in_w [4];
  logic [VAL_W-1:0]   in_value;
  logic [VAL_W-1:0]   item_cost;
  logic [VAL_W-1:0]   cur_denom;
  logic [VAL_W-1:0]   out_value;
  logic               overflow;

  function automatic logic [VAL_W-1:0] cost_of(input logic [1:0] item);
    case (item)
      2'd1:    return VAL_W'(COST_A);
      2'd2:    return VAL_W'(COST_B);
      2'd3:    return VAL_W'(COST_C);
      default: return '0;
    endcase
  endfunction

  function automatic logic [VAL_W-1:0] denom_value(input logic [1:0] d);
    case (d)
      2'd0:    return VAL_W'(50);
      2'd1:    return VAL_W'(10);
      2'd2:    return VAL_W'(5);
      default: return VAL_W'(1);
    endcase
  endfunction

  function automatic logic [VAL_W-1:0] coin_value(input logic [VAL_W-1:0] n50,
                                                  input logic [VAL_W-1:0] n10,
                                                  input logic [VAL_W-1:0] n5,
                                                  input logic [VAL_W-1:0] n1);
    return VAL_W'(50) * n50 + VAL_W'(10) * n10 + VAL_W'(5) * n5 + n1;
  endfunction

  assign coin_in_w[0] = coin_in_50_i;
  assign coin_in_w[1] = coin_in_10_i;
  assign coin_in_w[2] = coin_in_5_i;
  assign coin_in_w[3] = coin_in_1_i;

  assign accept    = (state_q == StIdle) && req_valid_i && (item_in_i != 2'b00);
  assign in_value  = coin_value(VAL_W'(coin_in_50_i), VAL_W'(coin_in_10_i),
                                VAL_W'(coin_in_5_i), VAL_W'(coin_in_1_i));
  assign item_cost = cost_of(item_q);
  assign cur_denom = denom_value(denom_q);
  assign out_value = coin_value(VAL_W'(coin_out_q[0]), VAL_W'(coin_out_q[1]),
                                VAL_W'(coin_out_q[2]), VAL_W'(coin_out_q[3]))
                     + cost_of(item_out_q);

  // Reject when accepting the inserted coins would overflow any inventory counter.
  always_comb begin
    overflow = 1'b0;
    for (int i = 0; i < 4; i++) begin
      if (SumW'(inv_q[i]) + SumW'(coin_in_q[i]) > SumW'(MaxCnt)) begin
        overflow = 1'b1;
      end
    end
  end

`ifdef VEND_REFILL_EN
  logic           refill_fire;
  logic [CNT_W:0] refill_sum;

  assign refill_ready_o = (state_q == StIdle) && !accept;
  assign refill_fire    = refill_valid_i && refill_ready_o;
  assign refill_sum     = {1'b0, inv_q[refill_denom_i]} + {1'b0, refill_num_i};
`endif

  always_ff @(posedge clk_i) begin
    if (!reset_ni) begin
      state_q    <= StIdle;
      item_q     <= '0;
      item_out_q <= '0;
      value_q    <= '0;
      remain_q   <= '0;
      denom_q    <= '0;
      done_q     <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        inv_q[i]      <= CNT_W'(INIT_CNT);
        coin_in_q[i]  <= '0;
        coin_out_q[i] <= '0;
      end
    end else begin
      done_q <= 1'b0;
`ifdef VEND_REFILL_EN
      if (refill_fire) begin
        inv_q[refill_denom_i] <= (refill_sum > (CNT_W + 1)'(MaxCnt)) ? CNT_W'(MaxCnt)
                                                                     : refill_sum[CNT_W-1:0];
      end
`endif
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            for (int i = 0; i < 4; i++) begin
              coin_in_q[i]  <= coin_in_w[i];
              coin_out_q[i] <= '0;
            end
            value_q    <= in_value;
            item_q     <= item_in_i;
            item_out_q <= '0;
            state_q    <= StCheck;
          end
        end
        StCheck: begin
          if (overflow || (value_q < item_cost)) begin
            for (int i = 0; i < 4; i++) begin
              coin_out_q[i] <= CNT_W'(coin_in_q[i]);
            end
            item_out_q <= '0;
            done_q     <= 1'b1;
            state_q    <= StDone;
          end else begin
            for (int i = 0; i < 4; i++) begin
              inv_q[i] <= inv_q[i] + CNT_W'(coin_in_q[i]);
            end
            remain_q   <= value_q - item_cost;
            item_out_q <= item_q;
            denom_q    <= 2'd0;
            state_q    <= StChange;
          end
        end
        StChange: begin
          if (remain_q >= cur_denom) begin
            if (inv_q[denom_q] != '0) begin
              coin_out_q[denom_q] <= coin_out_q[denom_q] + CNT_W'(1);
              inv_q[denom_q]      <= inv_q[denom_q] - CNT_W'(1);
              remain_q            <= remain_q - cur_denom;
            end else if (denom_q == 2'd3) begin
              state_q <= StRollback;
            end else begin
              denom_q <= denom_q + 2'd1;
            end
          end else if (denom_q == 2'd3) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end else begin
            denom_q <= denom_q + 2'd1;
          end
        end
        StRollback: begin
          // Undo the partial dispense and the deposit: inventory returns to its pre-request state.
          for (int i = 0; i < 4; i++) begin
            inv_q[i]      <= inv_q[i] + coin_out_q[i] - CNT_W'(coin_in_q[i]);
            coin_out_q[i] <= CNT_W'(coin_in_q[i]);
          end
          item_out_q <= '0;
          done_q     <= 1'b1;
          state_q    <= StDone;
        end
        StDone: begin
          state_q <= StIdle;
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign req_ready_o   = (state_q == StIdle);
  assign busy_o        = (state_q != StIdle);
  assign done_o        = done_q;
  assign coin_out_50_o = coin_out_q[0];
  assign coin_out_10_o = coin_out_q[1];
  assign coin_out_5_o  = coin_out_q[2];
  assign coin_out_1_o  = coin_out_q[3];
  assign item_out_o    = item_out_q;
  assign input_value_o = value_q;
  assign prop_ok_o     = (state_q != StDone) || (out_value == value_q);

endmodule

// File: tb/tb_vending_ctrl_gen2.sv
// Bench for vending_ctrl_gen2: transaction-level model of change making, checked every cycle,
// plus directed scenarios with hand-computed results.
module tb_vending_ctrl_gen2;

  localparam int CNT_W = 3;
  localparam int IN_W  = 2;
  localparam int VAL_W = 8;
  localparam int MAXC  = 7;
  localparam int INIT  = 2;

  logic             clk = 1'b0;
  logic             reset_n = 1'b0;
  logic             req_valid = 1'b0;
  logic             req_ready;
  logic [1:0]       item_in = '0;
  logic [IN_W-1:0]  c50 = '0, c10 = '0, c5 = '0, c1 = '0;
  logic [CNT_W-1:0] o50, o10, o5, o1;
  logic [1:0]       item_out;
  logic             busy, done, prop_ok;
  logic [VAL_W-1:0] input_value;

  always #5 clk = ~clk;

  vending_ctrl_gen2 dut (
    .clk_i         (clk),
    .reset_ni      (reset_n),
    .req_valid_i   (req_valid),
    .req_ready_o   (req_ready),
    .item_in_i     (item_in),
    .coin_in_50_i  (c50),
    .coin_in_10_i  (c10),
    .coin_in_5_i   (c5),
    .coin_in_1_i   (c1),
    .coin_out_50_o (o50),
    .coin_out_10_o (o10),
    .coin_out_5_o  (o5),
    .coin_out_1_o  (o1),
    .item_out_o    (item_out),
    .busy_o        (busy),
    .done_o        (done),
    .input_value_o (input_value),
    .prop_ok_o     (prop_ok)
`ifdef VEND_REFILL_EN
    ,
    .refill_valid_i (1'b0),
    .refill_denom_i (2'b00),
    .refill_num_i   ('0),
    .refill_ready_o ()
`endif
  );

  int checks = 0;
  int failures = 0;

  // Model state
  int denv [4] = '{50, 10, 5, 1};
  int cost [4] = '{0, 8, 15, 22};
  int inv [4];
  int m_out [4];
  int m_item;
  int m_value;
  int exp_left = 0;   // busy cycles still expected, the last one being the done cycle
  bit in_reset = 1'b1;
  int busy_cnt = 0;

  // Snapshot of the DUT at its done cycle, for directed literal checks
  int s_out [4];
  int s_item;
  int s_value;
  int s_done_cycle;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, want, $time);
    end
  endtask

  // Whole-transaction model: returns the number of busy cycles (CHECK through DONE).
  task automatic model_txn(input int item, input int cin [4], output int lat);
    int val, rem, k;
    bit ovf;
    int out [4];
    val = 50 * cin[0] + 10 * cin[1] + 5 * cin[2] + cin[3];
    ovf = 1'b0;
    for (int i = 0; i < 4; i++) if (inv[i] + cin[i] > MAXC) ovf = 1'b1;
    if (ovf || val < cost[item]) begin
      out = cin;
      m_item = 0;
      lat = 2;
    end else begin
      rem = val - cost[item];
      lat = 6;  // CHECK + one step per denomination + DONE
      for (int i = 0; i < 4; i++) begin
        k = rem / denv[i];
        if (k > inv[i] + cin[i]) k = inv[i] + cin[i];
        out[i] = k;
        rem -= k * denv[i];
        lat += k;
      end
      if (rem == 0) begin
        for (int i = 0; i < 4; i++) inv[i] += cin[i] - out[i];
        m_item = item;
      end else begin
        lat += 1;
        out = cin;
        m_item = 0;
      end
    end
    m_out = out;
    m_value = val;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 4; i++) begin
      inv[i] = INIT;
      m_out[i] = 0;
    end
    m_item = 0;
    m_value = 0;
    exp_left = 0;
  endtask

  task automatic do_reset();
    in_reset = 1'b1;
    reset_n = 1'b0;
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    model_reset();
    in_reset = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (exp_left != 0 && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("wait_idle_timeout", exp_left, 0);
    exp_left = 0;
  endtask

  task automatic txn(input int item, input int n50, input int n10, input int n5, input int n1);
    int cin [4];
    int lat;
    wait_idle();
    cin = '{n50, n10, n5, n1};
    req_valid = 1'b1;
    item_in = 2'(item);
    c50 = 2'(n50);
    c10 = 2'(n10);
    c5 = 2'(n5);
    c1 = 2'(n1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    item_in = 2'($urandom_range(0, 3));
    c50 = 2'($urandom);
    c10 = 2'($urandom);
    c5 = 2'($urandom);
    c1 = 2'($urandom);
    if (item != 0) begin
      model_txn(item, cin, lat);
      busy_cnt = 0;
      exp_left = lat;
    end
  endtask

  // Compare process: every cycle out of reset
  initial begin
    forever begin
      @(negedge clk);
      if (!in_reset) begin
        check("prop_ok", prop_ok, 1);
        check("input_value", input_value, m_value);
        if (exp_left > 0) begin
          busy_cnt++;
          check("req_ready_busy", req_ready, 0);
          check("busy", busy, 1);
          check("done", done, (exp_left == 1) ? 1 : 0);
          if (exp_left == 1) begin
            check("done_coin_out_50", o50, m_out[0]);
            check("done_coin_out_10", o10, m_out[1]);
            check("done_coin_out_5", o5, m_out[2]);
            check("done_coin_out_1", o1, m_out[3]);
            check("done_item_out", item_out, m_item);
            s_out = '{int'(o50), int'(o10), int'(o5), int'(o1)};
            s_item = int'(item_out);
            s_value = int'(input_value);
            s_done_cycle = busy_cnt + 1;  // counting the accepting cycle as cycle 1
          end
          exp_left--;
        end else begin
          check("req_ready_idle", req_ready, 1);
          check("busy_idle", busy, 0);
          check("done_idle", done, 0);
          check("idle_coin_out_50", o50, m_out[0]);
          check("idle_coin_out_10", o10, m_out[1]);
          check("idle_coin_out_5", o5, m_out[2]);
          check("idle_coin_out_1", o1, m_out[3]);
          check("idle_item_out", item_out, m_item);
        end
      end
    end
  end

  initial begin
    model_reset();
    @(posedge clk);
    #1;
    do_reset();

    // A with one 10: two 1s of change, count_1 drops to 0
    txn(1, 0, 1, 0, 0);
    wait_idle();
    check("lit_a10_out1", s_out[3], 2);
    check("lit_a10_out10", s_out[1], 0);
    check("lit_a10_item", s_item, 1);
    check("lit_a10_value", s_value, 10);
    check("lit_a10_cycles", s_done_cycle, 9);

    // Same again: no 1s left, so rollback returns the 10
    txn(1, 0, 1, 0, 0);
    wait_idle();
    check("lit_rb_out10", s_out[1], 1);
    check("lit_rb_out1", s_out[3], 0);
    check("lit_rb_item", s_item, 0);

    // C with 20: insufficient funds, done in the third cycle from accept
    do_reset();
    txn(3, 0, 2, 0, 0);
    wait_idle();
    check("lit_short_out10", s_out[1], 2);
    check("lit_short_item", s_item, 0);
    check("lit_short_cycles", s_done_cycle, 3);

    // Exact pay raises count_1 to 5; repeating it would overflow count_1 -> reject
    do_reset();
    txn(1, 0, 0, 1, 3);
    wait_idle();
    check("lit_exact_item", s_item, 1);
    check("lit_exact_out1", s_out[3], 0);
    txn(1, 0, 0, 1, 3);
    wait_idle();
    check("lit_rej_out1", s_out[3], 3);
    check("lit_rej_out5", s_out[2], 1);
    check("lit_rej_item", s_item, 0);
    check("lit_rej_cycles", s_done_cycle, 3);

    // Reset in the middle of CHANGE
    txn(1, 1, 0, 0, 0);
    repeat (4) begin
      @(posedge clk);
      #1;
    end
    check("lit_midchange_busy", busy, 1);
    do_reset();
    @(negedge clk);
    check("lit_rst_ready", req_ready, 1);
    check("lit_rst_out10", o10, 0);
    check("lit_rst_item", item_out, 0);
    @(posedge clk);
    #1;
    txn(1, 0, 1, 0, 0);
    wait_idle();
    check("lit_rst_restored_out1", s_out[3], 2);

    // Randomized traffic
    do_reset();
    for (int n = 0; n < 400; n++) begin
      txn($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
          $urandom_range(0, 3), $urandom_range(0, 3));
      if ($urandom_range(0, 39) == 0) begin
        repeat ($urandom_range(0, 5)) begin
          @(posedge clk);
          #1;
        end
        do_reset();
      end else begin
        repeat ($urandom_range(0, 2)) begin
          wait_idle();
          @(posedge clk);
          #1;
        end
      end
    end
    wait_idle();
    @(posedge clk);
    #1;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
